regdst_wb_tracker: RTL and testbench

//  Parametrised successor to the write-register destination mux for the multicycle MIPS datapath.
//  - Selects the destination register index.
//  - Carries the index through a STAGES-deep in-flight pipeline, aligned to register-file writeback.
//  - Tracks pending writes as a busy scoreboard.
//  - Stalls any issue whose source registers match an in-flight destination (RAW hazard).

---
 rtl/regdst_wb_tracker.sv | 108 ++++++++++
 tb/tb_regdst_wb_tracker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regdst_wb_tracker.sv
// Destination-register mux plus a STAGES-deep in-flight tracker with busy scoreboard and RAW stall.
// Optional build macro REGDST_ZERO_SUPPRESS_EN: treat register 0 as never written and never hazarding.
module regdst_wb_tracker #(
    parameter int REG_AW = 5,
    parameter int STAGES = 3,
    parameter int SP_IDX = 29,
    parameter int RA_IDX = 31
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  logic [1:0]                    dst_sel_i,
    input  logic [REG_AW-1:0]             rt_i,
    input  logic [REG_AW-1:0]             rd_i,
    input  logic [REG_AW-1:0]             src_a_i,
    input  logic [REG_AW-1:0]             src_b_i,
    input  logic                          flush_i,
    output logic                          wb_valid_o,
    output logic [REG_AW-1:0]             wb_dst_o,
    output logic                          stall_hazard_o,
    output logic [$clog2(STAGES+1)-1:0]   pending_count_o
);

    localparam int CW = $clog2(STAGES + 1);
    localparam logic [REG_AW-1:0] SP_SEL = REG_AW'(SP_IDX);
    localparam logic [REG_AW-1:0] RA_SEL = REG_AW'(RA_IDX);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [REG_AW-1:0] idx_q [STAGES];
    logic [REG_AW-1:0] idx_d [STAGES];
    logic [CW-1:0]     count_q, count_d;

    logic [REG_AW-1:0] sel_idx;
    logic              hit;
    logic              accept;
    logic              enter;

    always_comb begin
        sel_idx = SP_SEL;
        case (dst_sel_i)
            2'b00:   sel_idx = SP_SEL;
            2'b01:   sel_idx = rt_i;
            2'b10:   sel_idx = RA_SEL;
            default: sel_idx = rd_i;
        endcase
    end

    // The writeback stage is part of the search: the regfile does not bypass.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
`ifdef REGDST_ZERO_SUPPRESS_EN
            if (valid_q[i] && (((src_a_i == idx_q[i]) && (src_a_i != '0)) ||
                               ((src_b_i == idx_q[i]) && (src_b_i != '0))))
                hit = 1'b1;
`else
            if (valid_q[i] && ((src_a_i == idx_q[i]) || (src_b_i == idx_q[i])))
                hit = 1'b1;
`endif
        end
    end

    assign stall_hazard_o = hit;
    assign issue_ready_o  = ~hit & ~flush_i;
    assign accept         = issue_valid_i & issue_ready_o;

`ifdef REGDST_ZERO_SUPPRESS_EN
    assign enter = accept & (sel_idx != '0);
`else
    assign enter = accept;
`endif

    // Bubbles carry index 0 so idle stages stay deterministic.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = enter;
        idx_d[0]   = enter ? sel_idx : '0;
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            idx_d[i]   = idx_q[i-1];
        end
        if (flush_i)
            valid_d = '0;
        count_d = '0;
        for (int i = 0; i < STAGES; i++)
            count_d = count_d + CW'(valid_d[i]);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < STAGES; i++)
                idx_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < STAGES; i++)
                idx_q[i] <= idx_d[i];
        end
    end

    assign wb_valid_o      = valid_q[STAGES-1];
    assign wb_dst_o        = idx_q[STAGES-1];
    assign pending_count_o = count_q;

endmodule

// File: tb/tb_regdst_wb_tracker.sv
// Directed table-driven bench for regdst_wb_tracker (STAGES=3), plus reset-mid-flight sequence.
module tb_regdst_wb_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic       issue_ready;
    logic [1:0] dst_sel;
    logic [4:0] rt, rd, src_a, src_b;
    logic       flush;
    logic       wb_valid;
    logic [4:0] wb_dst;
    logic       stall_hazard;
    logic [1:0] pending_count;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    regdst_wb_tracker #(.REG_AW(5), .STAGES(3), .SP_IDX(29), .RA_IDX(31)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .issue_valid_i   (issue_valid),
        .issue_ready_o   (issue_ready),
        .dst_sel_i       (dst_sel),
        .rt_i            (rt),
        .rd_i            (rd),
        .src_a_i         (src_a),
        .src_b_i         (src_b),
        .flush_i         (flush),
        .wb_valid_o      (wb_valid),
        .wb_dst_o        (wb_dst),
        .stall_hazard_o  (stall_hazard),
        .pending_count_o (pending_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [1:0] sel;
        logic [4:0] rt, rd, sa, sb;
        logic       fl;
        logic       rdy, haz, wbv;
        logic [4:0] wbd;
        logic       cd;
        logic [1:0] pc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic iv, logic [1:0] sel, logic [4:0] rt_v, logic [4:0] rd_v,
                                logic [4:0] sa, logic [4:0] sb, logic fl, logic rdy, logic haz,
                                logic wbv, logic [4:0] wbd, logic cd, logic [1:0] pc);
        vec_t v;
        v.iv = iv; v.sel = sel; v.rt = rt_v; v.rd = rd_v; v.sa = sa; v.sb = sb; v.fl = fl;
        v.rdy = rdy; v.haz = haz; v.wbv = wbv; v.wbd = wbd; v.cd = cd; v.pc = pc;
        return v;
    endfunction

    function automatic vec_t idle(logic wbv, logic [4:0] wbd, logic [1:0] pc);
        return mk(1'b0, 2'b00, 5'd0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, wbv, wbd, wbv, pc);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        issue_valid = v.iv; dst_sel = v.sel; rt = v.rt; rd = v.rd;
        src_a = v.sa; src_b = v.sb; flush = v.fl;
    endtask

    // Scoreboard: every writeback must match the next expected index, in order.
    always @(posedge clk) begin
        #2;
        if (!reset && wb_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_wb: got wb_dst=%0d expected no writeback at %0t", wb_dst, $time);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if (wb_dst != e) begin
                    errors++;
                    $display("FAIL sb_wb_order: got wb_dst=%0d expected %0d at %0t", wb_dst, e, $time);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; issue_valid = 1'b0; dst_sel = 2'b00; rt = '0; rd = '0;
        src_a = 5'd1; src_b = 5'd2; flush = 1'b0;

        // iv sel rt rd sa sb fl | rdy haz wbv wbd cd pc
        vq.push_back(mk(0, 2'b00, 0, 0, 1, 2, 0, 1, 0, 0, 0, 1, 0));      // after reset
        vq.push_back(mk(1, 2'b11, 0, 8, 1, 2, 0, 1, 0, 0, 0, 0, 0));      // issue rd=8
        vq.push_back(idle(0, 0, 1));
        vq.push_back(idle(0, 0, 1));
        vq.push_back(idle(1, 8, 1));
        vq.push_back(idle(0, 0, 0));
        vq.push_back(mk(1, 2'b00, 3, 4, 1, 2, 0, 1, 0, 0, 0, 0, 0));      // $sp
        vq.push_back(mk(1, 2'b10, 3, 4, 1, 2, 0, 1, 0, 0, 0, 0, 1));      // $ra
        vq.push_back(idle(0, 0, 2));
        vq.push_back(idle(1, 29, 2));
        vq.push_back(idle(1, 31, 1));
        vq.push_back(idle(0, 0, 0));
        vq.push_back(mk(1, 2'b11, 0, 5, 1, 2, 0, 1, 0, 0, 0, 0, 0));      // issue rd=5
        vq.push_back(mk(1, 2'b11, 0, 9, 5, 2, 0, 0, 1, 0, 0, 0, 1));      // src_a=5 stalls
        vq.push_back(mk(1, 2'b11, 0, 9, 5, 2, 0, 0, 1, 0, 0, 0, 1));
        vq.push_back(mk(1, 2'b11, 0, 9, 5, 2, 0, 0, 1, 1, 5, 1, 1));      // stall covers wb stage
        vq.push_back(mk(1, 2'b11, 0, 9, 5, 2, 0, 1, 0, 0, 0, 0, 0));      // accepted now
        vq.push_back(idle(0, 0, 1));
        vq.push_back(idle(0, 0, 1));
        vq.push_back(idle(1, 9, 1));
        vq.push_back(idle(0, 0, 0));
        vq.push_back(mk(1, 2'b01, 12, 3, 1, 2, 0, 1, 0, 0, 0, 0, 0));     // rt=12
        vq.push_back(mk(0, 2'b00, 0, 0, 1, 12, 0, 0, 1, 0, 0, 0, 1));     // src_b hazard
        vq.push_back(idle(0, 0, 1));
        vq.push_back(idle(1, 12, 1));
        vq.push_back(idle(0, 0, 0));
        vq.push_back(mk(1, 2'b11, 0, 10, 1, 2, 0, 1, 0, 0, 0, 0, 0));     // fill three
        vq.push_back(mk(1, 2'b11, 0, 11, 1, 2, 0, 1, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 2'b11, 0, 13, 1, 2, 0, 1, 0, 0, 0, 0, 2));
        vq.push_back(mk(1, 2'b11, 0, 14, 1, 2, 1, 0, 0, 1, 10, 1, 3));    // flush + issue
        vq.push_back(idle(0, 0, 0));
        vq.push_back(idle(0, 0, 0));
        vq.push_back(idle(0, 0, 0));
        vq.push_back(idle(0, 0, 0));
        vq.push_back(mk(1, 2'b01, 0, 7, 1, 2, 0, 1, 0, 0, 0, 0, 0));      // rt=0
`ifdef REGDST_ZERO_SUPPRESS_EN
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0));      // src_a=0 never stalls
        vq.push_back(idle(0, 0, 0));
        vq.push_back(idle(0, 0, 0));
        vq.push_back(idle(0, 0, 0));
`else
        vq.push_back(mk(0, 2'b00, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 1));      // src_a=0 hits dest 0
        vq.push_back(idle(0, 0, 1));
        vq.push_back(idle(1, 0, 1));
        vq.push_back(idle(0, 0, 0));
`endif

        exp_q = '{5'd8, 5'd29, 5'd31, 5'd5, 5'd9, 5'd12, 5'd10};
`ifndef REGDST_ZERO_SUPPRESS_EN
        exp_q.push_back(5'd0);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            drive(vq[k]);
            #1;
            check($sformatf("row%0d_issue_ready", k), issue_ready, vq[k].rdy);
            check($sformatf("row%0d_stall_hazard", k), stall_hazard, vq[k].haz);
            check($sformatf("row%0d_wb_valid", k), wb_valid, vq[k].wbv);
            check($sformatf("row%0d_pending_count", k), pending_count, vq[k].pc);
            if (vq[k].cd)
                check($sformatf("row%0d_wb_dst", k), wb_dst, vq[k].wbd);
        end
        check("sb_drained", exp_q.size(), 0);

        // Reset one cycle after an accept: the in-flight write must vanish.
        @(negedge clk);
        drive(mk(1, 2'b11, 0, 20, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(idle(0, 0, 0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_wb_dst", wb_dst, 0);
        check("midreset_pending", pending_count, 0);
        check("midreset_ready", issue_ready, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("midreset_wb_valid%0d", k), wb_valid, 0);
            check($sformatf("midreset_pc%0d", k), pending_count, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
